branch_resolve_unit: RTL

Execute-stage branch resolution unit for the RISC-V core. Consumes the unsigned EQ/LT/GT flags from the 32-bit comparator, together with the operand sign bits, and decides BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR outcomes. On a taken decision it computes the target, issues a one-cycle redirect to fetch, and holds a fetch/decode flush for a fixed number of cycles. Fetch always predicts not-taken, so every taken control transfer is a redirect.

---
 rtl/branch_pkg.sv | 19 +
 rtl/branch_cond.sv | 34 +++
 rtl/branch_resolve_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the execute-stage branch resolution unit.
package branch_pkg;

  localparam int unsigned XLEN_DEF = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EVAL,
    ST_FLUSH
  } state_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition decode; signed less-than is rebuilt from the
// unsigned comparator result and the operand sign bits.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       cmp_eq,
  input  logic       cmp_lt,
  input  logic       rs1_sign,
  input  logic       rs2_sign,
  output logic       cond_true,
  output logic       illegal
);

  logic w_slt;

  // Differing signs: the negative operand (sign=1) is the smaller one.
  assign w_slt = (rs1_sign != rs2_sign) ? rs1_sign : cmp_lt;

  always_comb begin
    cond_true = 1'b0;
    illegal   = 1'b0;
    case (funct3)
      F3_BEQ:  cond_true = cmp_eq;
      F3_BNE:  cond_true = ~cmp_eq;
      F3_BLT:  cond_true = w_slt;
      F3_BGE:  cond_true = ~w_slt;
      F3_BLTU: cond_true = cmp_lt;
      F3_BGEU: cond_true = ~cmp_lt;
      default: illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver: latches an instruction, evaluates it for one
// cycle, pulses the result and holds a fetch/decode flush after a redirect.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            kill,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [2:0]      funct3,
  input  logic            cmp_eq,
  input  logic            cmp_lt,
  input  logic            cmp_gt,
  input  logic            rs1_sign,
  input  logic            rs2_sign,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            done,
  output logic            taken,
  output logic [XLEN-1:0] link_pc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            misalign,
  output logic            illegal
);

  localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t r_state, w_next;

  logic            r_is_branch, r_is_jal, r_is_jalr;
  logic [2:0]      r_funct3;
  logic            r_cmp_eq, r_cmp_lt, r_rs1_sign, r_rs2_sign;
  logic [XLEN-1:0] r_rs1_data, r_pc, r_imm;
  logic [CW-1:0]   r_cnt;

  logic            r_done, r_taken, r_redirect_valid, r_misalign, r_illegal;
  logic [XLEN-1:0] r_link_pc, r_redirect_pc;

  logic            w_accept, w_cond, w_cond_illegal, w_illegal;
  logic            w_want, w_misaligned, w_taken_ok, w_misalign;
  logic [XLEN-1:0] w_br_target, w_jalr_sum, w_target, w_link;
  logic            w_unused;

  assign w_accept = (r_state == ST_IDLE) && in_valid && !kill;

  branch_cond u_cond (
    .funct3    (r_funct3),
    .cmp_eq    (r_cmp_eq),
    .cmp_lt    (r_cmp_lt),
    .rs1_sign  (r_rs1_sign),
    .rs2_sign  (r_rs2_sign),
    .cond_true (w_cond),
    .illegal   (w_cond_illegal)
  );

  assign w_br_target  = r_pc + r_imm;
  assign w_jalr_sum   = r_rs1_data + r_imm;
  assign w_target     = r_is_jalr ? {w_jalr_sum[XLEN-1:1], 1'b0} : w_br_target;
  assign w_link       = r_pc + XLEN'(4);
  assign w_illegal    = r_is_branch && w_cond_illegal;
  assign w_want       = r_is_jal || r_is_jalr || (r_is_branch && w_cond && !w_cond_illegal);
  assign w_misaligned = (w_target[1:0] != 2'b00);
  assign w_taken_ok   = w_want && !w_misaligned;
  assign w_misalign   = w_want && w_misaligned;

  // The unsigned GT flag is implied by EQ/LT, and bit 0 of the JALR sum is forced to 0.
  assign w_unused = cmp_gt ^ w_jalr_sum[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (kill) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (in_valid) w_next = ST_EVAL;
        ST_EVAL:  w_next = w_taken_ok ? ST_FLUSH : ST_IDLE;
        ST_FLUSH: if (r_cnt == '0) w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (r_state == ST_IDLE);
    flush    = (r_state == ST_FLUSH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_EVAL) begin
      r_cnt <= CW'(FLUSH_CYCLES - 1);
    end else if (r_state == ST_FLUSH && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_branch <= 1'b0;
      r_is_jal    <= 1'b0;
      r_is_jalr   <= 1'b0;
      r_funct3    <= '0;
      r_cmp_eq    <= 1'b0;
      r_cmp_lt    <= 1'b0;
      r_rs1_sign  <= 1'b0;
      r_rs2_sign  <= 1'b0;
      r_rs1_data  <= '0;
      r_pc        <= '0;
      r_imm       <= '0;
    end else if (w_accept) begin
      r_is_branch <= is_branch;
      r_is_jal    <= is_jal;
      r_is_jalr   <= is_jalr;
      r_funct3    <= funct3;
      r_cmp_eq    <= cmp_eq;
      r_cmp_lt    <= cmp_lt;
      r_rs1_sign  <= rs1_sign;
      r_rs2_sign  <= rs2_sign;
      r_rs1_data  <= rs1_data;
      r_pc        <= pc;
      r_imm       <= imm;
    end
  end

  // Results live for exactly the cycle after EVAL; redirect_pc carries the target
  // even when the transfer faults, so it can be inspected alongside misalign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done           <= 1'b0;
      r_taken          <= 1'b0;
      r_link_pc        <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_misalign       <= 1'b0;
      r_illegal        <= 1'b0;
    end else if (r_state == ST_EVAL && !kill) begin
      r_done           <= 1'b1;
      r_taken          <= w_taken_ok;
      r_link_pc        <= w_link;
      r_redirect_valid <= w_taken_ok;
      r_redirect_pc    <= w_target;
      r_misalign       <= w_misalign;
      r_illegal        <= w_illegal;
    end else begin
      r_done           <= 1'b0;
      r_taken          <= 1'b0;
      r_link_pc        <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_misalign       <= 1'b0;
      r_illegal        <= 1'b0;
    end
  end

  assign done           = r_done;
  assign taken          = r_taken;
  assign link_pc        = r_link_pc;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign misalign       = r_misalign;
  assign illegal        = r_illegal;

endmodule
